// File: rtl/mem_responder.sv
// Wait-state memory responder: one access at a time, ready pulses WAIT_CYCLES+1 cycles after the request is sampled.
// Optional MEM_ALIGN_CHECK_EN flags misaligned addresses with err and suppresses their effect.
module mem_responder #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW        = 4;
    localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            cap_we;
    logic            cap_mis;
    logic [AW-1:0]   cap_idx;
    logic [31:0]     cap_wdata;
    logic [31:0]     mem [DEPTH];

    logic [AW-1:0]   req_idx;
    logic            req_mis;
    logic            unused_addr;

    // Upper address bits wrap; only the word index inside DEPTH is kept.
    assign req_idx = addr[AW+1:2];

`ifdef MEM_ALIGN_CHECK_EN
    assign req_mis     = |addr[1:0];
    assign unused_addr = ^addr[31:AW+2];
`else
    assign req_mis     = 1'b0;
    assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
    assign err         = 1'b0;
`endif

    // The access whose response starts next cycle; with zero wait states it comes straight from the ports.
    logic            resp_go_c;
    logic            resp_we_c;
    logic            resp_mis_c;
    logic [AW-1:0]   resp_idx_c;

    always_comb begin
        resp_go_c  = 1'b0;
        resp_we_c  = cap_we;
        resp_mis_c = cap_mis;
        resp_idx_c = cap_idx;
        case (state)
            IDLE: begin
                if (req && (WAIT_CYCLES == 0)) begin
                    resp_go_c  = 1'b1;
                    resp_we_c  = we;
                    resp_mis_c = req_mis;
                    resp_idx_c = req_idx;
                end
            end
            WAIT:    resp_go_c = (cnt == CW'(1));
            default: resp_go_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_we    <= 1'b0;
            cap_mis   <= 1'b0;
            cap_idx   <= '0;
            cap_wdata <= '0;
            ready     <= 1'b0;
            busy      <= 1'b0;
            rdata     <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            err       <= 1'b0;
`endif
        end else begin
            ready <= resp_go_c;
`ifdef MEM_ALIGN_CHECK_EN
            err   <= resp_go_c & resp_mis_c;
`endif
            if (resp_go_c && !resp_we_c && !resp_mis_c)
                rdata <= mem[resp_idx_c];

            case (state)
                IDLE: begin
                    if (req) begin
                        cap_we    <= we;
                        cap_mis   <= req_mis;
                        cap_idx   <= req_idx;
                        cap_wdata <= wdata;
                        cnt       <= WAIT_LOAD;
                        busy      <= 1'b1;
                        state     <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= RESP;
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage is never reset; a write lands on the edge that closes its response cycle.
    always_ff @(posedge clk) begin
        if (state == RESP && cap_we && !cap_mis)
            mem[cap_idx] <= cap_wdata;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: randomized accesses against an array model, plus directed corner cases.
module tb_mem_responder;

    localparam int unsigned DEPTH = 256;
    localparam int          W     = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req, we;
    logic [31:0] addr, wdata, rdata;
    logic        ready, busy, err;

    logic        req0, we0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        ready0, busy0, err0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .busy(busy), .err(err)
    );

    mem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .rdata(rdata0), .ready(ready0), .busy(busy0), .err(err0)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model [DEPTH];
    logic [31:0] last_rd = '0;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          bstart = -10;
    int          bend = -10;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: busy window every cycle, and each ready pulse against the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            check("busy", 32'(busy), 32'(cyc >= bstart && cyc <= bend));
            if (ready) begin
                if (q.size() == 0) begin
                    check("unexpected_ready", 32'(ready), 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("latency", 32'(cyc), 32'(e.cyc));
                    check("err", 32'(err), 32'(e.err));
                    check("rdata", rdata, e.rdata);
                end
            end
        end
    end

    // Issue one access at a negedge; garbage is driven while the DUT is busy, returning at the earliest next-issue negedge.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d);
        exp_t        e;
        int unsigned idx;
        logic        mis;
        idx = (a >> 2) % DEPTH;
        mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = (a[1:0] != 2'b00);
`endif
        if (!mis) begin
            if (w) model[idx] = d;
            else   last_rd = model[idx];
        end
        e.rdata = last_rd;
        e.err   = mis;
        e.cyc   = cyc + 1 + W;
        q.push_back(e);
        bstart = cyc + 1;
        bend   = cyc + 1 + W;
        req = 1'b1; we = w; addr = a; wdata = d;
        repeat (W + 1) begin
            @(negedge clk);
            req = 1'($urandom); we = 1'($urandom); addr = $urandom; wdata = $urandom;
        end
        @(negedge clk);
        req = 1'b0;
    endtask

    initial begin
        int t;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;

        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Zero-wait instance: response the cycle after the sample, busy for exactly one cycle.
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h0; wdata0 = 32'h12345678;
        @(negedge clk);
        check("w0_ready", 32'(ready0), 32'd1);
        check("w0_busy", 32'(busy0), 32'd1);
        req0 = 1'b0;
        @(negedge clk);
        check("w0_ready_low", 32'(ready0), 32'd0);
        check("w0_busy_low", 32'(busy0), 32'd0);
        req0 = 1'b1; we0 = 1'b0;
        @(negedge clk);
        check("r0_ready", 32'(ready0), 32'd1);
        check("r0_busy", 32'(busy0), 32'd1);
        check("r0_rdata", rdata0, 32'h12345678);
        check("r0_err", 32'(err0), 32'd0);
        req0 = 1'b0;
        @(negedge clk);
        check("r0_ready_low", 32'(ready0), 32'd0);
        check("r0_rdata_hold", rdata0, 32'h12345678);

        for (int i = 0; i < int'(DEPTH); i++)
            access(1'b1, 32'(i * 4), $urandom);

        access(1'b1, 32'h10, 32'hDEADBEEF);
        access(1'b0, 32'h10, 32'h0);
        access(1'b1, 32'h400, 32'hA5A5A5A5);
        access(1'b0, 32'h0, 32'h0);
        access(1'b1, 32'h20, 32'hCAFEF00D);
        access(1'b0, 32'h20, 32'h0);
        access(1'b1, 32'h6, 32'h77777777);
        access(1'b0, 32'h4, 32'h0);
        access(1'b0, 32'h6, 32'h0);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) @(negedge clk);
            access(1'($urandom_range(0, 1)), $urandom, $urandom);
        end

        // Reset during the wait states of a write: no response, and the old word survives.
        access(1'b1, 32'h8, 32'h0);
        bstart = cyc + 1;
        bend   = cyc + 1 + W;
        req = 1'b1; we = 1'b1; addr = 32'h8; wdata = 32'h11111111;
        @(negedge clk);
        req = 1'b0; addr = $urandom; wdata = $urandom;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_ready", 32'(ready), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        check("arst_rdata", rdata, 32'd0);
        bstart = -10;
        bend   = -10;
        last_rd = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (W + 4) @(negedge clk);
        access(1'b0, 32'h8, 32'h0);

        t = 0;
        while (q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("drain", 32'(q.size()), 32'd0);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning the number of 32-bit words stored (power of two).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, meaning the wait states inserted before each response (0..15).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port req  input  1  access request from the multicycle controller/datapath.
REQ-006 The block SHALL have port we  input  1  write enable for the request (1 = write, 0 = read).
REQ-007 The block SHALL have port addr  input  32  byte address.
REQ-008 The block SHALL have port wdata  input  32  write data.
REQ-009 The block SHALL have port rdata  output  32  read data, valid when ready=1 and the access was a read.
REQ-010 The block SHALL have port ready  output  1  one-cycle response pulse.
REQ-011 The block SHALL have port busy  output  1  high from request capture through the response cycle.
REQ-012 The block SHALL have port err  output  1  error flag, qualified by ready.

Function
REQ-013 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-014 In IDLE, req=1 at a rising edge SHALL capture addr, we and wdata, and SHALL load the wait counter with WAIT_CYCLES.
- Next state is WAIT if WAIT_CYCLES>0, else RESP.
REQ-015 In WAIT the counter SHALL decrement once per cycle, and the FSM SHALL move to RESP on the edge where the counter reaches 0.
REQ-016 Latency SHALL be exact: a request sampled at edge t SHALL give ready=1 during cycle t+1+WAIT_CYCLES.
REQ-017 In RESP, ready SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE unconditionally.
REQ-018 req, we, addr and wdata SHALL be ignored in WAIT and RESP, and captured values SHALL NOT change mid-access.
REQ-019 A write SHALL commit to storage at the edge ending RESP, using the captured address and data.
REQ-020 A read SHALL drive rdata from storage during RESP, and rdata SHALL hold its last read value at all other times, including write responses.
REQ-021 The word index SHALL be addr[log2(DEPTH)+1:2], with upper address bits ignored (address wrap-around).
REQ-022 Back-to-back accesses SHALL be allowed.
- req held high through RESP is sampled in IDLE on the following edge.
- This gives a minimum spacing of 2+WAIT_CYCLES cycles.
REQ-023 busy SHALL be 1 in WAIT and RESP, and 0 in IDLE.
REQ-024 A read of a word written by the immediately preceding access SHALL return the new data.

Reset
REQ-025 When rst is asserted, the state SHALL be IDLE and the outputs SHALL be ready=0, busy=0, err=0, rdata=0, with the counter at 0.
REQ-026 Reset mid-access SHALL abort the access: a pending write is discarded and no ready pulse occurs.
REQ-027 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-028 With MEM_ALIGN_CHECK_EN defined, a request with addr[1:0]!=0 SHALL still respond at normal latency with ready=1 and err=1.
- The write is suppressed.
- rdata is unchanged.
REQ-029 Without MEM_ALIGN_CHECK_EN, addr[1:0] SHALL be ignored and err SHALL be tied to 0.

Verification
REQ-030 Reset, then write 0xDEADBEEF to addr 0x10 and read addr 0x10 (WAIT_CYCLES=2) -> ready at cycle t+3 for each access, and the read returns 0xDEADBEEF.
REQ-031 With WAIT_CYCLES=0: write 0x12345678 to addr 0x0, then read -> ready one cycle after each request sample, rdata=0x12345678, busy high for one cycle per access.
REQ-032 With DEPTH=256: write 0xA5A5A5A5 to addr 0x400, then read addr 0x0 -> rdata=0xA5A5A5A5 (wrap-around).
REQ-033 Change addr, we and wdata during WAIT of a write to 0x20 -> only the captured write lands, and 0x20 reads back the original wdata.
REQ-034 Assert rst during WAIT of a write of 0x11111111 to 0x8 (old value 0x0) -> no ready pulse, outputs zero, and a later read of 0x8 returns 0x0.
REQ-035 With MEM_ALIGN_CHECK_EN defined: write to addr 0x6 -> ready=1 and err=1, memory unchanged; without the macro, the same write lands at word 1 with err=0.
